dmem_reg_core: RTL and testbench
================================

// Module: dmem_reg_core
// PURPOSE
//  Small-integration RV32I datapath slice: combinational ALU, data-memory bus request FSM, and a 32x32 register file.
//  The ALU computes result, branch and load/store addresses; the FSM runs one bus read or write per new load/store.
//  regWrite muxes the ALU result or loaded data back into the register file. Sits between decode and the external data bus.
// PARAMETERS
//  none; data width 32, 32 architectural registers, x0 hardwired to 0.
// PORTS
//  clk            in   1   system clock, rising edge
//  nrst           in   1   asynchronous active-low reset
//  MemToReg       in   1   1: regWrite=data_cpu_o, 0: regWrite=result
//  ALU_source     in   1   1: ALU operand B=immediate, 0: reg2
//  opcode         in   7   RV32I opcode
//  funct3         in   3   RV32I funct3
//  funct7         in   7   RV32I funct7 (bit5 selects SUB/SRA)
//  reg1, reg2     in   32  ALU operands (rs1/rs2 values)
//  immediate      in   32  sign-extended immediate
//  data_bus_i     in   32  read data from bus
//  data_good      in   1   bus completion strobe
//  rd, rs1, rs2   in   5   regfile write/read indices
//  writeEnable    in   1   regfile write enable
//  read_address   out  32  load address
//  write_address  out  32  store address
//  result         out  32  ALU result
//  branch         out  1   branch taken
//  data_read      out  1   bus read request
//  data_write     out  1   bus write request
//  data_adr_o     out  32  bus address
//  data_bus_o     out  32  bus write data
//  data_cpu_o     out  32  latched load data
//  regWrite       out  32  regfile write data
//  register1/2    out  32  regfile read data for rs1/rs2
// BEHAVIOUR
//  ALU (combinational): opB = ALU_source ? immediate : reg2.
//   0110011/0010011: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND by funct3/funct7[5]; SUB only for R-type; shift amount opB[4:0].
//   0000011 load: read_address=result=reg1+immediate, write_address=0.
//   0100011 store: write_address=result=reg1+immediate, read_address=0.
//   1100011: branch per funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU on reg1,reg2; result=0.
//   Other opcodes: result=0. read_address/write_address=0 for non-load/store; branch=0 when not B-type.
//  Bus FSM states IDLE, READ, WRITE, DONE:
//   IDLE: load -> READ; store -> WRITE; latch {opcode,read_address,write_address} as request key.
//   READ: data_read=1, data_adr_o=read_address; on data_good capture data_bus_i into data_cpu_o, go to DONE.
//   WRITE: data_write=1, data_adr_o=write_address, data_bus_o=reg2; on data_good go to DONE.
//   DONE: all requests low, data_adr_o=data_bus_o=0; return to IDLE when current key differs from latched key.
//   data_good in IDLE/DONE is ignored. Request outputs are registered; one cycle from accepted request to assertion.
//   data_cpu_o holds its value until the next completed read.
//  regWrite = MemToReg ? data_cpu_o : result (combinational).
//  Regfile: at posedge clk, if writeEnable and rd!=0, regs[rd]<=regWrite. Reads are combinational; index 0 returns 0.
//  Reset (nrst=0, async): FSM=IDLE; data_read, data_write=0; data_adr_o, data_bus_o, data_cpu_o=0; all regs=0.
//   Reset mid-transaction aborts the transaction.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if writeEnable and rd==rsN!=0, registerN=regWrite in the same cycle (write-through).
//  Undefined: registerN shows the old value until after the clock edge.
// TESTING
//  ALU to reg: R-type ADD, reg1=reg2=1, MemToReg=0, data_good=0 -> result=2, regWrite=2, addresses=0, all bus outputs 0.
//  Load: opcode 0000011, reg1=1, imm=1, data_bus_i=1, data_good=1, MemToReg=1
//   -> read_address=2, result=2; data_read=1 for one cycle then 0; data_cpu_o=1, regWrite=1.
//  Regfile writeback: after load, rd=rs1=1, rs2=0, writeEnable=1, one clock -> register1=1, register2=0.
//  Loop: feed register1/2 back as reg1/reg2, ADD -> result=1.
//  Store: opcode 0100011, reg1=4, imm=8, reg2=0xAB -> data_write=1, data_adr_o=12, data_bus_o=0xAB until data_good, then DONE with outputs 0.
//  Branch/reset: BEQ reg1=reg2=5 -> branch=1; BLTU 0xFFFFFFFF<1 -> 0; nrst low mid-READ -> data_read=0, data_cpu_o=0 immediately.

Source files
------------

// File: rtl/dmem_reg_core.sv
// RV32I datapath slice: combinational ALU, one-shot data-bus request FSM and a 32x32 register file.
// Define REGFILE_BYPASS_EN to forward same-cycle register writes to the read ports.
module dmem_reg_core (
   input  logic        clk,
   input  logic        nrst,
   input  logic        MemToReg,
   input  logic        ALU_source,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] reg1,
   input  logic [31:0] reg2,
   input  logic [31:0] immediate,
   input  logic [31:0] data_bus_i,
   input  logic        data_good,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic        writeEnable,
   output logic [31:0] read_address,
   output logic [31:0] write_address,
   output logic [31:0] result,
   output logic        branch,
   output logic        data_read,
   output logic        data_write,
   output logic [31:0] data_adr_o,
   output logic [31:0] data_bus_o,
   output logic [31:0] data_cpu_o,
   output logic [31:0] regWrite,
   output logic [31:0] register1,
   output logic [31:0] register2
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} bus_state_t;

   bus_state_t  state, next_state;
   logic [31:0] op_b;
   logic [70:0] cur_key, req_key, key_next;
   logic [31:0] req_data, data_next;
   logic        data_read_n, data_write_n;
   logic [31:0] data_adr_n, data_bus_n;
   logic [31:0] regs [32];
   logic        unused_funct7;

   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      op_b          = ALU_source ? immediate : reg2;
      result        = '0;
      read_address  = '0;
      write_address = '0;
      branch        = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            case (funct3)
               3'b000:  result = (opcode == OP_R && funct7[5]) ? reg1 - op_b : reg1 + op_b;
               3'b001:  result = reg1 << op_b[4:0];
               3'b010:  result = {31'b0, $signed(reg1) < $signed(op_b)};
               3'b011:  result = {31'b0, reg1 < op_b};
               3'b100:  result = reg1 ^ op_b;
               3'b101:  result = funct7[5] ? 32'($signed(reg1) >>> op_b[4:0]) : reg1 >> op_b[4:0];
               3'b110:  result = reg1 | op_b;
               default: result = reg1 & op_b;
            endcase
         end
         OP_LOAD: begin
            result       = reg1 + immediate;
            read_address = reg1 + immediate;
         end
         OP_STORE: begin
            result        = reg1 + immediate;
            write_address = reg1 + immediate;
         end
         OP_BRANCH: begin
            case (funct3)
               3'b000:  branch = (reg1 == reg2);
               3'b001:  branch = (reg1 != reg2);
               3'b100:  branch = ($signed(reg1) < $signed(reg2));
               3'b101:  branch = ($signed(reg1) >= $signed(reg2));
               3'b110:  branch = (reg1 < reg2);
               3'b111:  branch = (reg1 >= reg2);
               default: branch = 1'b0;
            endcase
         end
         default: result = '0;
      endcase
   end

   // The key identifies one memory instruction; DONE waits for it to change so a held load/store runs once.
   assign cur_key  = {opcode, read_address, write_address};
   assign key_next = (state == IDLE) ? cur_key : req_key;
   assign data_next = (state == IDLE) ? reg2 : req_data;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         req_key    <= '0;
         req_data   <= '0;
         data_read  <= 1'b0;
         data_write <= 1'b0;
         data_adr_o <= '0;
         data_bus_o <= '0;
         data_cpu_o <= '0;
      end else begin
         state      <= next_state;
         req_key    <= key_next;
         req_data   <= data_next;
         data_read  <= data_read_n;
         data_write <= data_write_n;
         data_adr_o <= data_adr_n;
         data_bus_o <= data_bus_n;
         if (state == READ && data_good)
            data_cpu_o <= data_bus_i;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (opcode == OP_LOAD)
               next_state = READ;
            else if (opcode == OP_STORE)
               next_state = WRITE;
         end
         READ:    if (data_good) next_state = DONE;
         WRITE:   if (data_good) next_state = DONE;
         default: if (cur_key != req_key) next_state = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so requests appear one cycle after acceptance.
   always_comb begin
      data_read_n  = 1'b0;
      data_write_n = 1'b0;
      data_adr_n   = '0;
      data_bus_n   = '0;
      case (next_state)
         READ: begin
            data_read_n = 1'b1;
            data_adr_n  = key_next[63:32];
         end
         WRITE: begin
            data_write_n = 1'b1;
            data_adr_n   = key_next[31:0];
            data_bus_n   = data_next;
         end
         default: data_read_n = 1'b0;
      endcase
   end

   assign regWrite = MemToReg ? data_cpu_o : result;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else if (writeEnable && rd != 5'd0) begin
         regs[rd] <= regWrite;
      end
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      register1 = (rs1 == 5'd0) ? '0 : regs[rs1];
      register2 = (rs2 == 5'd0) ? '0 : regs[rs2];
      if (writeEnable && rd != 5'd0 && rd == rs1)
         register1 = regWrite;
      if (writeEnable && rd != 5'd0 && rd == rs2)
         register2 = regWrite;
   end
`else
   assign register1 = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign register2 = (rs2 == 5'd0) ? '0 : regs[rs2];
`endif

endmodule

// File: tb/tb_dmem_reg_core.sv
// Self-checking bench for dmem_reg_core: ALU vector table, bus-transaction scoreboard and regfile checks.
module tb_dmem_reg_core;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic        clk = 1'b0;
   logic        nrst;
   logic        MemToReg, ALU_source, data_good, writeEnable;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] reg1, reg2, immediate, data_bus_i;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] read_address, write_address, result, data_adr_o, data_bus_o, data_cpu_o;
   logic [31:0] regWrite, register1, register2;
   logic        branch, data_read, data_write;

   typedef struct {
      logic        isWrite;
      logic [31:0] adr;
      logic [31:0] data;
   } busExp_t;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b, imm;
      logic        src;
      logic [31:0] expResult;
      logic        expBranch;
   } aluVec_t;

   busExp_t busQ[$];
   aluVec_t aluVecs[$];
   int      numCompared = 0;
   int      numMismatched = 0;
   logic    sawRead;

   dmem_reg_core dut (
      .clk(clk), .nrst(nrst), .MemToReg(MemToReg), .ALU_source(ALU_source),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .reg1(reg1), .reg2(reg2), .immediate(immediate),
      .data_bus_i(data_bus_i), .data_good(data_good),
      .rd(rd), .rs1(rs1), .rs2(rs2), .writeEnable(writeEnable),
      .read_address(read_address), .write_address(write_address),
      .result(result), .branch(branch),
      .data_read(data_read), .data_write(data_write),
      .data_adr_o(data_adr_o), .data_bus_o(data_bus_o), .data_cpu_o(data_cpu_o),
      .regWrite(regWrite), .register1(register1), .register2(register2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic src);
      opcode     = op;
      funct3     = f3;
      funct7     = f7;
      reg1       = a;
      reg2       = b;
      immediate  = imm;
      ALU_source = src;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every cycle a request is up it must match the oldest expected transaction; completion pops it.
   always @(negedge clk) begin
      if (nrst && (data_read || data_write)) begin
         if (busQ.size() == 0) begin
            checkOutput("busUnexpected", {30'b0, data_write, data_read}, 32'd0);
         end else begin
            checkOutput("busKind", {31'b0, data_write}, {31'b0, busQ[0].isWrite});
            checkOutput("busAdr", data_adr_o, busQ[0].adr);
            if (busQ[0].isWrite)
               checkOutput("busData", data_bus_o, busQ[0].data);
            if (data_good)
               void'(busQ.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      aluVecs.push_back('{OP_R,      3'b000, 7'h00, 32'd1,        32'd1,  32'd0,   1'b0, 32'd2,        1'b0});
      aluVecs.push_back('{OP_R,      3'b000, 7'h20, 32'd5,        32'd7,  32'd0,   1'b0, 32'hFFFFFFFE, 1'b0});
      aluVecs.push_back('{OP_I,      3'b000, 7'h20, 32'd5,        32'd0,  32'd3,   1'b1, 32'd8,        1'b0});
      aluVecs.push_back('{OP_I,      3'b000, 7'h00, 32'd2,        32'd3,  32'd100, 1'b0, 32'd5,        1'b0});
      aluVecs.push_back('{OP_R,      3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd1,        1'b0});
      aluVecs.push_back('{OP_R,      3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd0,        1'b0});
      aluVecs.push_back('{OP_R,      3'b001, 7'h00, 32'd1,        32'd31, 32'd0,   1'b0, 32'h80000000, 1'b0});
      aluVecs.push_back('{OP_I,      3'b001, 7'h00, 32'd1,        32'd0,  32'd35,  1'b1, 32'd8,        1'b0});
      aluVecs.push_back('{OP_R,      3'b101, 7'h00, 32'h80000000, 32'd4,  32'd0,   1'b0, 32'h08000000, 1'b0});
      aluVecs.push_back('{OP_R,      3'b101, 7'h20, 32'h80000000, 32'd4,  32'd0,   1'b0, 32'hF8000000, 1'b0});
      aluVecs.push_back('{OP_R,      3'b100, 7'h00, 32'hF0F0,     32'h0FF0, 32'd0, 1'b0, 32'hFF00,     1'b0});
      aluVecs.push_back('{OP_R,      3'b110, 7'h00, 32'hF0F0,     32'h0FF0, 32'd0, 1'b0, 32'hFFF0,     1'b0});
      aluVecs.push_back('{OP_R,      3'b111, 7'h00, 32'hF0F0,     32'h0FF0, 32'd0, 1'b0, 32'h00F0,     1'b0});
      aluVecs.push_back('{7'b0110111, 3'b000, 7'h00, 32'd9,       32'd9,  32'd9,   1'b1, 32'd0,        1'b0});
      aluVecs.push_back('{OP_BRANCH, 3'b000, 7'h00, 32'd5,        32'd5,  32'd9,   1'b1, 32'd0,        1'b1});
      aluVecs.push_back('{OP_BRANCH, 3'b001, 7'h00, 32'd5,        32'd5,  32'd0,   1'b0, 32'd0,        1'b0});
      aluVecs.push_back('{OP_BRANCH, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd0,        1'b1});
      aluVecs.push_back('{OP_BRANCH, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd0,        1'b0});
      aluVecs.push_back('{OP_BRANCH, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd0,        1'b0});
      aluVecs.push_back('{OP_BRANCH, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1,  32'd0,   1'b0, 32'd0,        1'b1});

      nrst = 1'b0;
      MemToReg = 1'b0;
      data_good = 1'b0;
      writeEnable = 1'b0;
      data_bus_i = '0;
      rd = 5'd0;
      rs1 = 5'd1;
      rs2 = 5'd0;
      applyStimulus(7'd0, 3'd0, 7'd0, '0, '0, '0, 1'b0);
      #2;
      checkOutput("rstDataRead", {31'b0, data_read}, 32'd0);
      checkOutput("rstDataWrite", {31'b0, data_write}, 32'd0);
      checkOutput("rstAdr", data_adr_o, 32'd0);
      checkOutput("rstBusO", data_bus_o, 32'd0);
      checkOutput("rstCpuO", data_cpu_o, 32'd0);
      checkOutput("rstReg1", register1, 32'd0);
      nextCycle();
      nrst = 1'b1;

      // ALU to reg
      nextCycle();
      applyStimulus(OP_R, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("addResult", result, 32'd2);
      checkOutput("addRegWrite", regWrite, 32'd2);
      checkOutput("addReadAdr", read_address, 32'd0);
      checkOutput("addWriteAdr", write_address, 32'd0);
      @(negedge clk);
      checkOutput("addBusIdle", {data_read, data_write, 30'b0}, 32'd0);
      checkOutput("addBusAdr", data_adr_o | data_bus_o, 32'd0);

      foreach (aluVecs[i]) begin
         nextCycle();
         applyStimulus(aluVecs[i].op, aluVecs[i].f3, aluVecs[i].f7, aluVecs[i].a,
                       aluVecs[i].b, aluVecs[i].imm, aluVecs[i].src);
         @(negedge clk);
         checkOutput($sformatf("aluResult%0d", i), result, aluVecs[i].expResult);
         checkOutput($sformatf("aluBranch%0d", i), {31'b0, branch}, {31'b0, aluVecs[i].expBranch});
      end

      // Load with completion already waiting
      nextCycle();
      applyStimulus(OP_LOAD, 3'b010, 7'h00, 32'd1, 32'd0, 32'd1, 1'b1);
      data_bus_i = 32'd1;
      data_good = 1'b1;
      MemToReg = 1'b1;
      busQ.push_back('{1'b0, 32'd2, 32'd0});
      @(negedge clk);
      checkOutput("ldReadAdr", read_address, 32'd2);
      checkOutput("ldResult", result, 32'd2);
      checkOutput("ldWriteAdr", write_address, 32'd0);
      checkOutput("ldReadBefore", {31'b0, data_read}, 32'd0);
      @(negedge clk);
      checkOutput("ldReadHigh", {31'b0, data_read}, 32'd1);
      @(negedge clk);
      checkOutput("ldReadLow", {31'b0, data_read}, 32'd0);
      checkOutput("ldCpuO", data_cpu_o, 32'd1);
      checkOutput("ldRegWrite", regWrite, 32'd1);

      // Regfile writeback
      nextCycle();
      data_good = 1'b0;
      rd = 5'd1;
      rs1 = 5'd1;
      rs2 = 5'd0;
      writeEnable = 1'b1;
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      checkOutput("wbBypass", register1, 32'd1);
`else
      checkOutput("wbNoBypass", register1, 32'd0);
`endif
      nextCycle();
      rd = 5'd0;
      @(negedge clk);
      checkOutput("wbReg1", register1, 32'd1);
      checkOutput("wbReg2", register2, 32'd0);
      nextCycle();
      writeEnable = 1'b0;
      @(negedge clk);
      checkOutput("wbX0", register2, 32'd0);

      // Loop the register file back through the ALU
      nextCycle();
      MemToReg = 1'b0;
      applyStimulus(OP_R, 3'b000, 7'h00, register1, register2, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("loopResult", result, 32'd1);

      // data_good outside READ/WRITE must not disturb the loaded value
      nextCycle();
      data_good = 1'b1;
      data_bus_i = 32'h55;
      repeat (2) @(negedge clk);
      checkOutput("idleGoodCpuO", data_cpu_o, 32'd1);
      checkOutput("idleGoodRead", {31'b0, data_read}, 32'd0);

      // Store held until the bus acknowledges
      nextCycle();
      data_good = 1'b0;
      applyStimulus(OP_STORE, 3'b010, 7'h00, 32'd4, 32'hAB, 32'd8, 1'b1);
      busQ.push_back('{1'b1, 32'd12, 32'hAB});
      @(negedge clk);
      checkOutput("stWriteAdr", write_address, 32'd12);
      checkOutput("stReadAdr", read_address, 32'd0);
      checkOutput("stResult", result, 32'd12);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("stWriteHigh", {31'b0, data_write}, 32'd1);
         checkOutput("stAdr", data_adr_o, 32'd12);
         checkOutput("stBusO", data_bus_o, 32'hAB);
      end
      nextCycle();
      data_good = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("stDoneWrite", {31'b0, data_write}, 32'd0);
      checkOutput("stDoneAdr", data_adr_o, 32'd0);
      checkOutput("stDoneBusO", data_bus_o, 32'd0);

      // Reset in the middle of a read
      nextCycle();
      data_good = 1'b0;
      applyStimulus(OP_LOAD, 3'b010, 7'h00, 32'h100, 32'd0, 32'd0, 1'b1);
      busQ.push_back('{1'b0, 32'h100, 32'd0});
      sawRead = 1'b0;
      for (int c = 0; c < 10 && !sawRead; c++) begin
         @(negedge clk);
         sawRead = data_read;
      end
      checkOutput("rdStarted", {31'b0, sawRead}, 32'd1);
      checkOutput("rdCpuHeld", data_cpu_o, 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      checkOutput("abortRead", {31'b0, data_read}, 32'd0);
      checkOutput("abortCpuO", data_cpu_o, 32'd0);
      checkOutput("abortReg1", register1, 32'd0);
      busQ.delete();
      applyStimulus(7'd0, 3'd0, 7'd0, '0, '0, '0, 1'b0);
      nextCycle();
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("postRstRead", {31'b0, data_read}, 32'd0);

      checkOutput("busPending", busQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
